// File: rtl/writeback_pipe_pkg.sv
// Shared Y86-64 writeback constants: stat codes, register IDs, icodes and bubble values.
package writeback_pipe_pkg;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] BUBBLE_STAT  = STAT_AOK;
  localparam logic [3:0] BUBBLE_ICODE = I_NOP;
  localparam logic [3:0] BUBBLE_DST   = RNONE;

endpackage

// File: rtl/writeback_pipe_reg_file.sv
// Architectural register file: two write ports (M wins on collision), two combinational reads.
// Optional write-through read ports when WB_BYPASS_EN is defined.
module writeback_pipe_reg_file
  import writeback_pipe_pkg::*;
#(
  parameter int unsigned NREGS = 15,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             weE,
  input  logic [3:0]       dstE,
  input  logic [WIDTH-1:0] valE,
  input  logic             weM,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valM,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [WIDTH-1:0] rvalA,
  output logic [WIDTH-1:0] rvalB
);

  logic [WIDTH-1:0] regs [NREGS];

  function automatic logic inRange(input logic [3:0] id);
    return (id != RNONE) && (int'(id) < int'(NREGS));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      if (weE && inRange(dstE)) regs[dstE] <= valE;
      // Later assignment wins: popq %rsp keeps the loaded value.
      if (weM && inRange(dstM)) regs[dstM] <= valM;
    end
  end

  function automatic logic [WIDTH-1:0] readPort(input logic [3:0] src);
    logic [WIDTH-1:0] v;
    v = inRange(src) ? regs[src] : '0;
`ifdef WB_BYPASS_EN
    if (weM && dstM == src && inRange(src)) v = valM;
    else if (weE && dstE == src && inRange(src)) v = valE;
`endif
    return v;
  endfunction

  always_comb begin
    rvalA = readPort(srcA);
    rvalB = readPort(srcB);
  end

endmodule

// File: rtl/writeback_pipe.sv
// Y86-64 writeback stage: W pipeline register with sticky halt, feeding the register file.
// Define WB_BYPASS_EN for write-through decode read ports.
module writeback_pipe
  import writeback_pipe_pkg::*;
#(
  parameter int unsigned NREGS = 15,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [WIDTH-1:0] m_valE,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [3:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [WIDTH-1:0] W_valE,
  output logic [WIDTH-1:0] W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [WIDTH-1:0] d_rvalA,
  output logic [WIDTH-1:0] d_rvalB,
  output logic [3:0]       cpu_stat
);

  logic             hold;
  logic             weE;
  logic             weM;

  // A faulting instruction in W freezes the stage until reset.
  assign hold = W_stall || (W_stat != STAT_AOK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_stat  <= BUBBLE_STAT;
      W_icode <= BUBBLE_ICODE;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= BUBBLE_DST;
      W_dstM  <= BUBBLE_DST;
    end else if (hold) begin
      W_stat  <= W_stat;
    end else if (W_bubble) begin
      W_stat  <= BUBBLE_STAT;
      W_icode <= BUBBLE_ICODE;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= BUBBLE_DST;
      W_dstM  <= BUBBLE_DST;
    end else begin
      W_stat  <= m_stat;
      W_icode <= m_icode;
      W_valE  <= m_valE;
      W_valM  <= m_valM;
      W_dstE  <= m_dstE;
      W_dstM  <= m_dstM;
    end
  end

  assign weE      = (W_stat == STAT_AOK) && (W_dstE != RNONE);
  assign weM      = (W_stat == STAT_AOK) && (W_dstM != RNONE);
  assign cpu_stat = W_stat;

  writeback_pipe_reg_file #(
    .NREGS(NREGS),
    .WIDTH(WIDTH)
  ) u_reg_file (
    .clk  (clk),
    .reset(reset),
    .weE  (weE),
    .dstE (W_dstE),
    .valE (W_valE),
    .weM  (weM),
    .dstM (W_dstM),
    .valM (W_valM),
    .srcA (d_srcA),
    .srcB (d_srcB),
    .rvalA(d_rvalA),
    .rvalB(d_rvalB)
  );

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed self-checking bench for writeback_pipe (WB_BYPASS_EN changes same-cycle read checks).
module tb_writeback_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  m_stat, m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic        W_stall, W_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, cpu_stat;
  logic [63:0] W_valE, W_valM, d_rvalA, d_rvalB;

  int nChecks = 0;
  int nPass   = 0;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] RN  = 4'hF;

  always #5 clk = ~clk;

  writeback_pipe dut (
    .clk     (clk),
    .reset   (reset),
    .m_stat  (m_stat),
    .m_icode (m_icode),
    .m_valE  (m_valE),
    .m_valM  (m_valM),
    .m_dstE  (m_dstE),
    .m_dstM  (m_dstM),
    .W_stall (W_stall),
    .W_bubble(W_bubble),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .W_stat  (W_stat),
    .W_icode (W_icode),
    .W_valE  (W_valE),
    .W_valM  (W_valM),
    .W_dstE  (W_dstE),
    .W_dstM  (W_dstM),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB),
    .cpu_stat(cpu_stat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setM(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                      input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
    m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
  endtask

  task automatic setNop();
    setM(AOK, 4'h1, 64'd0, 64'd0, RN, RN);
  endtask

  initial begin
    reset = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; d_srcA = 4'd3; d_srcB = 4'd4;
    setNop();
    #2;
    check("rst_stat", {60'd0, W_stat}, {60'd0, AOK});
    check("rst_icode", {60'd0, W_icode}, 64'd1);
    check("rst_dstE", {60'd0, W_dstE}, {60'd0, RN});
    check("rst_cpu_stat", {60'd0, cpu_stat}, {60'd0, AOK});
    check("rst_rvalA", d_rvalA, 64'd0);
    #10 reset = 1'b0;

    // irmovq $2000, %rbx
    setM(AOK, 4'h3, 64'd2000, 64'd0, 4'd3, RN);
    tick();
    check("irmovq_W_valE", W_valE, 64'd2000);
    check("irmovq_W_dstE", {60'd0, W_dstE}, 64'd3);
`ifdef WB_BYPASS_EN
    check("irmovq_bypass_read", d_rvalA, 64'd2000);
`else
    check("irmovq_no_bypass_read", d_rvalA, 64'd0);
`endif
    setNop();
    tick();
    check("irmovq_reg3", d_rvalA, 64'd2000);

    // popq %rsp: valM wins over valE
    setM(AOK, 4'hB, 64'd108, 64'd49, 4'd4, 4'd4);
    tick();
    check("popq_W_valM", W_valM, 64'd49);
    setNop();
    tick();
    check("popq_reg4", d_rvalB, 64'd49);

    // Bubble discards m_*
    d_srcA = 4'd5;
    W_bubble = 1'b1;
    setM(AOK, 4'h6, 64'd100, 64'd0, 4'd5, RN);
    tick();
    check("bubble_dstE", {60'd0, W_dstE}, {60'd0, RN});
    check("bubble_icode", {60'd0, W_icode}, 64'd1);
    check("bubble_valE", W_valE, 64'd0);
    W_bubble = 1'b0;
    setNop();
    tick();
    check("bubble_reg5", d_rvalA, 64'd0);

    // Stall beats bubble
    setM(AOK, 4'h2, 64'd55, 64'd0, 4'd7, RN);
    tick();
    W_stall = 1'b1; W_bubble = 1'b1;
    setM(AOK, 4'h6, 64'd99, 64'd0, 4'd8, RN);
    tick();
    check("stall_dstE", {60'd0, W_dstE}, 64'd7);
    check("stall_valE", W_valE, 64'd55);
    check("stall_icode", {60'd0, W_icode}, 64'd2);
    W_stall = 1'b0; W_bubble = 1'b0;
    setNop();
    tick();

    // Register 14 with all ones; RNONE reads zero
    setM(AOK, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'd14, RN);
    tick();
    setNop();
    tick();
    d_srcA = RN; d_srcB = 4'd14;
    #1;
    check("rnone_read", d_rvalA, 64'd0);
    check("reg14_read", d_rvalB, 64'hFFFF_FFFF_FFFF_FFFF);

    // Address fault freezes W and suppresses writes
    d_srcA = 4'd6;
    setM(ADR, 4'h5, 64'd0, 64'd77, RN, 4'd6);
    tick();
    check("adr_cpu_stat", {60'd0, cpu_stat}, {60'd0, ADR});
    check("adr_reg6_now", d_rvalA, 64'd0);
    setM(AOK, 4'h3, 64'd1, 64'd0, 4'd6, RN);
    W_bubble = 1'b1;
    tick();
    tick();
    check("adr_sticky_stat", {60'd0, W_stat}, {60'd0, ADR});
    check("adr_sticky_dstM", {60'd0, W_dstM}, 64'd6);
    check("adr_sticky_valM", W_valM, 64'd77);
    check("adr_reg6_later", d_rvalA, 64'd0);
    W_bubble = 1'b0;

    // Reset mid-run clears W and the register file
    d_srcA = 4'd3;
    #2 reset = 1'b1;
    #1;
    check("midrst_stat", {60'd0, cpu_stat}, {60'd0, AOK});
    check("midrst_dstM", {60'd0, W_dstM}, {60'd0, RN});
    check("midrst_reg3", d_rvalA, 64'd0);
    setM(AOK, 4'h3, 64'd5, 64'd0, 4'd9, RN);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_load_dstE", {60'd0, W_dstE}, 64'd9);
    check("post_rst_load_valE", W_valE, 64'd5);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

Writeback stage of the Y86-64 pipeline: holds the W pipeline register fed by the memory stage outputs (m_*), commits valE/valM into the 15-entry architectural register file, and serves the decode stage's two combinational read ports. Also produces the processor status that halts the pipeline on HLT/ADR/INS.

## Interface
Parameters:
- NREGS, 15, architectural registers (IDs 0..14; 4'hF = RNONE)
- WIDTH, 64, data width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- m_stat  input  4  status from memory stage (one-hot)
- m_icode  input  4  instruction code from memory stage
- m_valE  input  64  ALU result
- m_valM  input  64  memory read value
- m_dstE  input  4  destination for valE (RNONE = none)
- m_dstM  input  4  destination for valM (RNONE = none)
- W_stall  input  1  hold W register
- W_bubble  input  1  load W register with bubble
- d_srcA  input  4  decode read port A register ID
- d_srcB  input  4  decode read port B register ID
- W_stat, W_icode  output  4 each  W register contents
- W_valE, W_valM  output  64 each  W register contents
- W_dstE, W_dstM  output  4 each  W register contents
- d_rvalA, d_rvalB  output  64 each  register file read data
- cpu_stat  output  4  processor status (= effective W_stat)

## Operation
- Stat codes (one-hot): AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001.
- Bubble value: stat=AOK, icode=1 (nop), valE=valM=0, dstE=dstM=RNONE.
- W register update at posedge clk, priority order: W_stall or sticky halt -> hold; W_bubble -> bubble; else load m_*.
- Sticky halt: once W_stat != AOK, W register holds regardless of W_stall/W_bubble until reset.
- Register file writes at posedge using the W contents present before the edge:
  - write W_valE to W_dstE if W_dstE != RNONE and W_stat == AOK
  - write W_valM to W_dstM if W_dstM != RNONE and W_stat == AOK
  - W_dstE == W_dstM (both valid): W_valM wins (popq %rsp semantics)
- Reads: d_rvalA = regs[d_srcA], d_rvalB = regs[d_srcB]; RNONE reads 0.
- cpu_stat = W_stat; a bubble reports AOK.

## Timing
- Reset (async, immediate): W register = bubble, all registers = 0, cpu_stat = AOK, d_rvalA/B = 0.
- Reset deasserted mid-operation: first active edge loads m_* normally.
- Latency: m_* -> W_* one cycle; W_* -> register file visible one further cycle (without bypass).
- Read ports purely combinational from register file state (plus bypass, below).
- W_stall and W_bubble same cycle: stall wins.
- Faulting instruction (stat != AOK) reaches W: no register write that cycle or afterwards; pipeline frozen.

## Configuration
- WB_BYPASS_EN defined: read ports are write-through — if d_srcX matches an active write this cycle (W_dstM, then W_dstE, same enable rules as writes), d_rvalX returns the value being written. Decode sees results in the same cycle W holds them.
- Not defined: read ports return stored register contents only; decode forwarding must use W_valE/W_valM directly.

## Structure
- Shared package: stat encodings (AOK/HLT/ADR/INS), RNONE, icode constants (HALT, NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ), bubble values.
- One sub-module: reg_file (15x64, two write ports with M priority, two combinational read ports, async reset, optional bypass).
- W register and sticky-halt logic in the top.

## Test plan
- Reset mid-run with regs populated -> all outputs bubble values, reading register 3 gives 0.
- m_icode=3 (irmovq), m_stat=AOK, m_valE=2000, m_dstE=3 -> W_valE=2000 after edge 1; d_srcA=3 reads 2000 after edge 2 (same cycle as W with WB_BYPASS_EN).
- m_icode=11 (popq), m_dstE=m_dstM=4, m_valE=108, m_valM=49 -> register 4 = 49.
- W_bubble=1 with m_dstE=5, m_valE=100 -> W_dstE=RNONE, register 5 unchanged; W_stall=1 and W_bubble=1 together -> W holds previous values.
- m_stat=ADR, m_dstM=6, m_valM=77 -> cpu_stat=ADR, register 6 not written; later m_* changes and W_bubble ignored until reset.
- d_srcA=RNONE, d_srcB=14 after writing 14 with 64'hFFFF_FFFF_FFFF_FFFF -> d_rvalA=0, d_rvalB=all ones.
